// File: rtl/csr_counter.sv
// ---------------------------------------------------------------------------
// csr_counter
// Read-only cycle / instret performance counters with a MEM-stage decode and
// a W-stage aligned result register for the writeback data mux.
//
// Parameters
//   ALIAS_EN      1 = machine aliases 0xB00/0xB80/0xB02/0xB82 decode like
//                 the user counters 0xC00/0xC80/0xC02/0xC82.
//
// Ports
//   clk           pipeline clock, all state updates on the rising edge
//   rst           synchronous, active-high reset
//   stall         pipeline stall, holds the M->W result register
//   flush_M       kills the instruction in MEM (no read forwarded to W)
//   csr_rd_M      instruction in MEM is a CSR read
//   csr_addr_M    CSR address of that instruction
//   retire_W      an instruction retires in WB this cycle
//   CSR_cyc       W-stage CSR read data
//   csr_illegal_W W-stage read targeted an undecoded address
// ---------------------------------------------------------------------------
module csr_counter #(
    parameter bit ALIAS_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush_M,
    input  logic        csr_rd_M,
    input  logic [11:0] csr_addr_M,
    input  logic        retire_W,
    output logic [31:0] CSR_cyc,
    output logic        csr_illegal_W
);

    localparam int unsigned CNT_W  = 64;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 12;

    localparam logic [ADDR_W-1:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [ADDR_W-1:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [ADDR_W-1:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [ADDR_W-1:0] ADDR_INSTRETH = 12'hC82;
    localparam logic [ADDR_W-1:0] ALIAS_OFFSET  = 12'h100;

    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_instret;
    logic [DATA_W-1:0] r_csr_cyc;
    logic              r_illegal;

    logic [ADDR_W-1:0] w_addr;
    logic              w_is_alias;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_rd_hit;

    // Free-running cycle counter; counts through stalls and flushes, wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_W'(1);
        end
    end

    // Retired-instruction counter; WB retirement is independent of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (retire_W) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Fold the machine aliases onto the user addresses before decoding.
    always_comb begin
        w_is_alias = 1'b0;
        w_addr     = csr_addr_M;
        if (ALIAS_EN) begin
            w_is_alias = (csr_addr_M == (ADDR_CYCLE    - ALIAS_OFFSET)) ||
                         (csr_addr_M == (ADDR_CYCLEH   - ALIAS_OFFSET)) ||
                         (csr_addr_M == (ADDR_INSTRET  - ALIAS_OFFSET)) ||
                         (csr_addr_M == (ADDR_INSTRETH - ALIAS_OFFSET));
        end
        if (w_is_alias) begin
            w_addr = csr_addr_M + ALIAS_OFFSET;
        end
    end

    // MEM-stage read decode; uses pre-increment counter values.
    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b1;
        case (w_addr)
            ADDR_CYCLE:    w_rd_data = r_cycle[DATA_W-1:0];
            ADDR_CYCLEH:   w_rd_data = r_cycle[CNT_W-1:DATA_W];
            ADDR_INSTRET:  w_rd_data = r_instret[DATA_W-1:0];
            ADDR_INSTRETH: w_rd_data = r_instret[CNT_W-1:DATA_W];
            default:       w_rd_hit  = 1'b0;
        endcase
    end

    // M->W result register; stall holds it and outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_csr_cyc <= '0;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            if (flush_M || !csr_rd_M) begin
                r_csr_cyc <= '0;
                r_illegal <= 1'b0;
            end else begin
                r_csr_cyc <= w_rd_data;
                r_illegal <= !w_rd_hit;
            end
        end
    end

    assign CSR_cyc       = r_csr_cyc;
    assign csr_illegal_W = r_illegal;

endmodule

// File: tb/tb_csr_counter.sv
// ---------------------------------------------------------------------------
// tb_csr_counter
// Self-checking bench for csr_counter: one instance with aliases enabled and
// one with aliases disabled share the stimulus. A counter/readout model kept
// in the bench predicts the W-stage outputs of both.
// ---------------------------------------------------------------------------
module tb_csr_counter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush_M;
    logic        csr_rd_M;
    logic [11:0] csr_addr_M;
    logic        retire_W;
    logic [31:0] CSR_cyc;
    logic        csr_illegal_W;
    logic [31:0] CSR_cyc_na;
    logic        csr_illegal_W_na;

    int checks;
    int errors;

    // Reference state: counter values as the specification defines them.
    logic [63:0] m_cyc;
    logic [63:0] m_cyc_na;
    logic [63:0] m_ins;
    logic [31:0] exp_data;
    logic        exp_ill;
    logic [31:0] exp_data_na;
    logic        exp_ill_na;

    csr_counter #(.ALIAS_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush_M(flush_M),
        .csr_rd_M(csr_rd_M), .csr_addr_M(csr_addr_M), .retire_W(retire_W),
        .CSR_cyc(CSR_cyc), .csr_illegal_W(csr_illegal_W)
    );

    csr_counter #(.ALIAS_EN(1'b0)) dut_na (
        .clk(clk), .rst(rst), .stall(stall), .flush_M(flush_M),
        .csr_rd_M(csr_rd_M), .csr_addr_M(csr_addr_M), .retire_W(retire_W),
        .CSR_cyc(CSR_cyc_na), .csr_illegal_W(csr_illegal_W_na)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Address map: returns {illegal, data} for a read of address a.
    function automatic logic [32:0] ref_csr(input logic [11:0] a, input bit alias_en,
                                            input logic [63:0] cy, input logic [63:0] ir);
        logic [11:0] u;
        u = a;
        if (alias_en && (a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82))
            u = a + 12'h100;
        case (u)
            12'hC00: return {1'b0, cy[31:0]};
            12'hC80: return {1'b0, cy[63:32]};
            12'hC02: return {1'b0, ir[31:0]};
            12'hC82: return {1'b0, ir[63:32]};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // Predict outputs from the current inputs, advance one clock, update model.
    task automatic tick();
        logic [32:0] r;
        if (rst) begin
            exp_data = '0; exp_ill = 1'b0; exp_data_na = '0; exp_ill_na = 1'b0;
        end else if (!stall) begin
            if (flush_M || !csr_rd_M) begin
                exp_data = '0; exp_ill = 1'b0; exp_data_na = '0; exp_ill_na = 1'b0;
            end else begin
                r = ref_csr(csr_addr_M, 1'b1, m_cyc, m_ins);
                {exp_ill, exp_data} = r;
                r = ref_csr(csr_addr_M, 1'b0, m_cyc_na, m_ins);
                {exp_ill_na, exp_data_na} = r;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_cyc = '0; m_cyc_na = '0; m_ins = '0;
        end else begin
            m_cyc    = m_cyc + 64'd1;
            m_cyc_na = m_cyc_na + 64'd1;
            if (retire_W) m_ins = m_ins + 64'd1;
        end
    endtask

    task automatic idle_inputs();
        stall = 1'b0; flush_M = 1'b0; csr_rd_M = 1'b0; csr_addr_M = '0; retire_W = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stall    = 1'($urandom_range(0, 1));
            retire_W = 1'($urandom_range(0, 1));
            csr_rd_M = 1'b1; csr_addr_M = 12'hC00;
            tick();
        end
        checks++;
        if (CSR_cyc !== 32'h0 || csr_illegal_W !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: CSR_cyc=%h ill=%b required 0/0", CSR_cyc, csr_illegal_W);
        end
        checks++;
        if (dut.r_cycle !== 64'h0 || dut.r_instret !== 64'h0) begin
            errors++;
            $display("FAIL reset_cnt: cycle=%h instret=%h required 0/0", dut.r_cycle, dut.r_instret);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_release_read();
        // rst was just released: model cycle is 0 now
        for (int i = 0; i < 5; i++) tick();
        csr_rd_M = 1'b1; csr_addr_M = 12'hC00;
        tick();
        checks++;
        if (CSR_cyc !== 32'd5 || csr_illegal_W !== 1'b0) begin
            errors++;
            $display("FAIL release_read: CSR_cyc=%0d ill=%b required 5/0", CSR_cyc, csr_illegal_W);
        end
        idle_inputs();
    endtask

    task automatic test_instret();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            retire_W = 1'b1; tick();
            retire_W = 1'b0; tick();
        end
        csr_rd_M = 1'b1; csr_addr_M = 12'hC02; retire_W = 1'b1;
        tick();
        checks++;
        if (CSR_cyc !== 32'd3) begin
            errors++;
            $display("FAIL instret_same_edge: CSR_cyc=%0d required 3", CSR_cyc);
        end
        retire_W = 1'b0;
        tick();
        checks++;
        if (CSR_cyc !== 32'd4) begin
            errors++;
            $display("FAIL instret_next: CSR_cyc=%0d required 4", CSR_cyc);
        end
        idle_inputs();
    endtask

    task automatic test_carry();
        idle_inputs();
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.r_cycle;
        m_cyc = 64'h0000_0000_FFFF_FFFF;
        csr_rd_M = 1'b1; csr_addr_M = 12'hC00;
        tick();
        checks++;
        if (CSR_cyc !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL carry_lo: CSR_cyc=%h required ffffffff", CSR_cyc);
        end
        csr_addr_M = 12'hC80;
        tick();
        checks++;
        if (CSR_cyc !== 32'h0000_0001) begin
            errors++;
            $display("FAIL carry_hi: CSR_cyc=%h required 00000001", CSR_cyc);
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [31:0] sampled;
        csr_rd_M = 1'b1; csr_addr_M = 12'hC00;
        tick();
        sampled = CSR_cyc;
        checks++;
        if (CSR_cyc !== exp_data) begin
            errors++;
            $display("FAIL stall_sample: CSR_cyc=%h required %h", CSR_cyc, exp_data);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            csr_addr_M = (i == 1) ? 12'h123 : 12'hC02;
            flush_M    = (i == 2);
            tick();
            checks++;
            if (CSR_cyc !== sampled || csr_illegal_W !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: CSR_cyc=%h ill=%b required %h/0",
                         i, CSR_cyc, csr_illegal_W, sampled);
            end
        end
        stall = 1'b0; flush_M = 1'b0; csr_addr_M = 12'hC00;
        tick();
        checks++;
        if (CSR_cyc !== exp_data || (CSR_cyc - sampled) < 32'd4) begin
            errors++;
            $display("FAIL stall_release: CSR_cyc=%h required %h (>= %h+4)", CSR_cyc, exp_data, sampled);
        end
        idle_inputs();
    endtask

    task automatic test_illegal();
        csr_rd_M = 1'b1; csr_addr_M = 12'h123;
        tick();
        checks++;
        if (CSR_cyc !== 32'h0 || csr_illegal_W !== 1'b1) begin
            errors++;
            $display("FAIL illegal_123: CSR_cyc=%h ill=%b required 0/1", CSR_cyc, csr_illegal_W);
        end
        csr_addr_M = 12'hC00; flush_M = 1'b1;
        tick();
        checks++;
        if (CSR_cyc !== 32'h0 || csr_illegal_W !== 1'b0) begin
            errors++;
            $display("FAIL flush_read: CSR_cyc=%h ill=%b required 0/0", CSR_cyc, csr_illegal_W);
        end
        flush_M = 1'b0;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: csr_addr_M = 12'hB00;
                1: csr_addr_M = 12'hB80;
                2: csr_addr_M = 12'hB02;
                default: csr_addr_M = 12'hB82;
            endcase
            retire_W = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (csr_illegal_W_na !== 1'b1 || CSR_cyc_na !== 32'h0) begin
                errors++;
                $display("FAIL noalias_%h: ill=%b data=%h required 1/0",
                         csr_addr_M, csr_illegal_W_na, CSR_cyc_na);
            end
            checks++;
            if (csr_illegal_W !== 1'b0 || CSR_cyc !== exp_data) begin
                errors++;
                $display("FAIL alias_%h: ill=%b data=%h required 0/%h",
                         csr_addr_M, csr_illegal_W, CSR_cyc, exp_data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [11:0] addrs [10];
        addrs = '{12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hB00,
                  12'hB80, 12'hB02, 12'hB82, 12'h123, 12'hC01};
        for (int n = 0; n < 400; n++) begin
            stall      = ($urandom_range(0, 3) == 0);
            flush_M    = ($urandom_range(0, 5) == 0);
            csr_rd_M   = ($urandom_range(0, 3) != 0);
            csr_addr_M = addrs[$urandom_range(0, 9)];
            retire_W   = 1'($urandom_range(0, 1));
            rst        = ($urandom_range(0, 99) == 0);
            tick();
            checks++;
            if (CSR_cyc !== exp_data || csr_illegal_W !== exp_ill) begin
                errors++;
                $display("FAIL rand_alias n=%0d: data=%h ill=%b required %h/%b",
                         n, CSR_cyc, csr_illegal_W, exp_data, exp_ill);
            end
            checks++;
            if (CSR_cyc_na !== exp_data_na || csr_illegal_W_na !== exp_ill_na) begin
                errors++;
                $display("FAIL rand_noalias n=%0d: data=%h ill=%b required %h/%b",
                         n, CSR_cyc_na, csr_illegal_W_na, exp_data_na, exp_ill_na);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 6; i++) begin
            retire_W = 1'b1; tick();
        end
        retire_W = 1'b1; csr_rd_M = 1'b1; csr_addr_M = 12'hC02; rst = 1'b1; stall = 1'b0;
        checks++;
        if (dut.r_cycle === 64'h0 || dut.r_instret === 64'h0) begin
            errors++;
            $display("FAIL midreset_pre: cycle=%h instret=%h required nonzero",
                     dut.r_cycle, dut.r_instret);
        end
        tick();
        checks++;
        if (CSR_cyc !== 32'h0 || csr_illegal_W !== 1'b0 ||
            dut.r_cycle !== m_cyc || dut.r_instret !== m_ins) begin
            errors++;
            $display("FAIL midreset: data=%h ill=%b cycle=%h instret=%h required 0/0/%h/%h",
                     CSR_cyc, csr_illegal_W, dut.r_cycle, dut.r_instret, m_cyc, m_ins);
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_cyc = '0; m_cyc_na = '0; m_ins = '0;
        exp_data = '0; exp_ill = 1'b0; exp_data_na = '0; exp_ill_na = 1'b0;
        rst = 1'b1;
        idle_inputs();
        #2;
        test_reset();
        test_release_read();
        test_instret();
        test_carry();
        test_stall();
        test_illegal();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
